// File: rtl/clk_phase_ctrl_if.sv
// Purpose: bundles the control, configuration and status signals between the
//          adaptive clock-phase controller and its environment (error detector,
//          configuration registers and the delay stage).
// Ports:   master drives en/err_in/cfg_*, observes mode/delay_sel/state_o/sw_cnt;
//          slave (the controller) is the mirror image.
interface clk_phase_ctrl_if;
  // environment -> controller
  logic       en;          // adaptive-clocking enable, 0 forces IDLE
  logic       err_in;      // timing-warning pulse, sampled every cycle
  logic [3:0] cfg_win;     // monitoring window length minus one
  logic [3:0] cfg_thresh;  // errors per window that trigger LEAD, 0 disables
  logic [7:0] cfg_hold;    // LEAD hold length minus one

  // controller -> environment
  logic       mode;        // 1: adaptive selection active
  logic       delay_sel;   // 0: leading phase, 1: origin phase
  logic [1:0] state_o;     // 0 IDLE, 1 ORIGIN, 2 LEAD
  logic [7:0] sw_cnt;      // saturating count of ORIGIN->LEAD switches

  modport master (
    output en, err_in, cfg_win, cfg_thresh, cfg_hold,
    input  mode, delay_sel, state_o, sw_cnt
  );

  modport slave (
    input  en, err_in, cfg_win, cfg_thresh, cfg_hold,
    output mode, delay_sel, state_o, sw_cnt
  );
endinterface

// File: rtl/clk_phase_ctrl.sv
// Purpose: adaptive clock-phase controller. Counts timing warnings inside a
//          programmable window and switches the delay stage to the leading
//          phase when a threshold is hit, holding it until the errors stop.
// Ports:   clk, rst (async, active-high); bus (slave modport) carries en,
//          err_in, cfg_win/cfg_thresh/cfg_hold in and mode, delay_sel,
//          state_o, sw_cnt out. All outputs come straight from flops.
module clk_phase_ctrl (
  input  logic             clk,
  input  logic             rst,
  clk_phase_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ORIGIN = 2'd1,
    LEAD   = 2'd2,
    BAD    = 2'd3   // unreachable encoding, recovers to IDLE
  } state_t;

  state_t     state;
  logic [3:0] win_cnt;
  logic [3:0] err_cnt;
  logic [7:0] hold_cnt;
  logic [7:0] sw_q;
  logic       mode_q;
  logic       dsel_q;

  // Error count including the current cycle's pulse. One extra bit so the
  // comparison against the threshold cannot wrap when err_cnt is saturated.
  logic [4:0] err_sum;
  logic       thresh_hit;
  logic       win_end;
  logic [3:0] err_next;
  logic [7:0] sw_next;

  assign err_sum    = {1'b0, err_cnt} + {4'b0000, bus.err_in};
  assign thresh_hit = (bus.cfg_thresh != 4'd0) &&
                      (err_sum >= {1'b0, bus.cfg_thresh});
  assign win_end    = (win_cnt == bus.cfg_win);
  assign err_next   = (err_cnt == 4'hF) ? 4'hF
                                        : err_cnt + {3'b000, bus.err_in};
  assign sw_next    = (sw_q == 8'hFF) ? 8'hFF : sw_q + 8'd1;

  // Single state machine. mode/delay_sel are registered together with the
  // next state so they always agree with state_o and have no input-to-output
  // combinational path. The reset value of delay_sel is 1, so asserting rst
  // in LEAD returns the delay stage to the origin phase without a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      win_cnt  <= 4'd0;
      err_cnt  <= 4'd0;
      hold_cnt <= 8'd0;
      sw_q     <= 8'd0;
      mode_q   <= 1'b0;
      dsel_q   <= 1'b1;
    end else if (!bus.en) begin
      // Disable wins over every other transition.
      state    <= IDLE;
      win_cnt  <= 4'd0;
      err_cnt  <= 4'd0;
      hold_cnt <= 8'd0;
      mode_q   <= 1'b0;
      dsel_q   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state   <= ORIGIN;
          win_cnt <= 4'd0;
          err_cnt <= 4'd0;
          mode_q  <= 1'b1;
          dsel_q  <= 1'b1;
        end

        ORIGIN: begin
          if (thresh_hit) begin
            // Threshold reached: go to the leading phase on the next edge.
            state    <= LEAD;
            hold_cnt <= bus.cfg_hold;
            win_cnt  <= 4'd0;
            err_cnt  <= 4'd0;
            sw_q     <= sw_next;
            mode_q   <= 1'b1;
            dsel_q   <= 1'b0;
          end else if (win_end) begin
            // Window closes. The pulse on its last cycle was already folded
            // into err_sum above and did not reach the threshold, so it is
            // dropped with the rest of the window.
            win_cnt <= 4'd0;
            err_cnt <= 4'd0;
          end else begin
            win_cnt <= win_cnt + 4'd1;
            err_cnt <= err_next;
          end
        end

        LEAD: begin
          if (bus.err_in) begin
            // Any fresh warning restarts the hold period.
            hold_cnt <= bus.cfg_hold;
          end else if (hold_cnt == 8'd0) begin
            // Window/error counters were cleared on LEAD entry and are not
            // touched in LEAD, so ORIGIN restarts with a fresh window.
            state  <= ORIGIN;
            mode_q <= 1'b1;
            dsel_q <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end

        default: begin
          state    <= IDLE;
          win_cnt  <= 4'd0;
          err_cnt  <= 4'd0;
          hold_cnt <= 8'd0;
          mode_q   <= 1'b0;
          dsel_q   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.mode      = mode_q;
  assign bus.delay_sel = dsel_q;
  assign bus.state_o   = state;
  assign bus.sw_cnt    = sw_q;

endmodule

// File: tb/tb_clk_phase_ctrl.sv
module tb_clk_phase_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  clk_phase_ctrl_if bus();

  clk_phase_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Absolute time limit; the directed sequence needs well under 2000 cycles.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [1:0] st, input logic md,
                            input logic ds, input logic [7:0] sw);
    chk({tag, ".state"},     {30'd0, bus.state_o}, {30'd0, st});
    chk({tag, ".mode"},      {31'd0, bus.mode},    {31'd0, md});
    chk({tag, ".delay_sel"}, {31'd0, bus.delay_sel}, {31'd0, ds});
    chk({tag, ".sw_cnt"},    {24'd0, bus.sw_cnt},  {24'd0, sw});
  endtask

  initial begin
    bus.en         = 1'b0;
    bus.err_in     = 1'b0;
    bus.cfg_win    = 4'd7;
    bus.cfg_thresh = 4'd2;
    bus.cfg_hold   = 8'd3;

    // Reset state, applied asynchronously before any clock edge.
    #1 rst = 1'b1;
    #1;
    expect_out("reset_async", 2'd0, 1'b0, 1'b1, 8'd0);

    bus.en = 1'b1;
    step();
    step();
    expect_out("reset_held", 2'd0, 1'b0, 1'b1, 8'd0);

    // Release reset with en=0: no state change until an edge with en=1.
    bus.en = 1'b0;
    #4 rst = 1'b0;
    step();
    expect_out("post_rst_en0", 2'd0, 1'b0, 1'b1, 8'd0);

    // Enable with no errors for 100 cycles: ORIGIN throughout.
    bus.en = 1'b1;
    step();
    expect_out("enable_first_edge", 2'd1, 1'b1, 1'b1, 8'd0);
    for (int i = 0; i < 100; i++) begin
      step();
      chk("quiet_state", {30'd0, bus.state_o}, 32'd1);
      chk("quiet_dsel",  {31'd0, bus.delay_sel}, 32'd1);
    end
    expect_out("quiet_end", 2'd1, 1'b1, 1'b1, 8'd0);

    // Realign the window: en low for one edge, then back to ORIGIN (cycle 0).
    bus.en = 1'b0;
    step();
    expect_out("en_drop_origin", 2'd0, 1'b0, 1'b1, 8'd0);
    bus.en = 1'b1;
    step();

    // Errors at window cycles 2 and 5 with threshold 2 -> LEAD for 4 cycles.
    step();                                   // cycle 0
    step();                                   // cycle 1
    bus.err_in = 1'b1; step(); bus.err_in = 1'b0;   // cycle 2
    expect_out("one_err_origin", 2'd1, 1'b1, 1'b1, 8'd0);
    step();                                   // cycle 3
    step();                                   // cycle 4
    bus.err_in = 1'b1; step(); bus.err_in = 1'b0;   // cycle 5
    for (int i = 0; i < 4; i++) begin
      expect_out("lead_hold3", 2'd2, 1'b1, 1'b0, 8'd1);
      step();
    end
    expect_out("lead_exit", 2'd1, 1'b1, 1'b1, 8'd1);

    // Errors at cycle 7 of one window and cycle 0 of the next: no switch.
    repeat (7) step();                        // cycles 0..6
    bus.err_in = 1'b1;
    step();                                   // cycle 7, window clears
    step();                                   // cycle 0 of next window
    bus.err_in = 1'b0;
    expect_out("window_straddle", 2'd1, 1'b1, 1'b1, 8'd1);

    // The cycle-0 error was kept: one more at cycle 1 reaches the threshold.
    bus.err_in = 1'b1; step(); bus.err_in = 1'b0;
    expect_out("second_in_window", 2'd2, 1'b1, 1'b0, 8'd2);

    // Hold reload: error arrives while hold_cnt is 1.
    step();                                   // hold 3 -> 2
    chk("reload_h2", {31'd0, bus.delay_sel}, 32'd0);
    step();                                   // hold 2 -> 1
    chk("reload_h1", {31'd0, bus.delay_sel}, 32'd0);
    bus.err_in = 1'b1; step(); bus.err_in = 1'b0;   // reload to 3
    for (int i = 0; i < 4; i++) begin
      expect_out("reload_hold", 2'd2, 1'b1, 1'b0, 8'd2);
      step();
    end
    expect_out("reload_exit", 2'd1, 1'b1, 1'b1, 8'd2);

    // cfg_hold=0, cfg_thresh=1: a single error gives exactly one LEAD cycle.
    bus.en = 1'b0; step();
    bus.cfg_hold = 8'd0; bus.cfg_thresh = 4'd1;
    bus.en = 1'b1; step();
    bus.err_in = 1'b1; step(); bus.err_in = 1'b0;
    expect_out("hold0_lead", 2'd2, 1'b1, 1'b0, 8'd3);
    step();
    expect_out("hold0_exit", 2'd1, 1'b1, 1'b1, 8'd3);

    // cfg_win=0: one-cycle window, threshold 2 can never be reached.
    bus.en = 1'b0; step();
    bus.cfg_win = 4'd0; bus.cfg_thresh = 4'd2; bus.cfg_hold = 8'd3;
    bus.en = 1'b1; step();
    bus.err_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("win0_state", {30'd0, bus.state_o}, 32'd1);
    end
    bus.err_in = 1'b0;
    expect_out("win0_end", 2'd1, 1'b1, 1'b1, 8'd3);

    // cfg_thresh=0 disables switching even with continuous errors.
    bus.en = 1'b0; step();
    bus.cfg_win = 4'd7; bus.cfg_thresh = 4'd0;
    bus.en = 1'b1; step();
    bus.err_in = 1'b1;
    for (int i = 0; i < 64; i++) begin
      step();
      chk("thresh0_state", {30'd0, bus.state_o}, 32'd1);
      chk("thresh0_dsel",  {31'd0, bus.delay_sel}, 32'd1);
    end
    bus.err_in = 1'b0;
    expect_out("thresh0_end", 2'd1, 1'b1, 1'b1, 8'd3);

    // en dropped in LEAD.
    bus.en = 1'b0; step();
    bus.cfg_thresh = 4'd2;
    bus.en = 1'b1; step();
    bus.err_in = 1'b1; step(); step(); bus.err_in = 1'b0;
    expect_out("pre_drop_lead", 2'd2, 1'b1, 1'b0, 8'd4);
    bus.en = 1'b0; step();
    expect_out("en_drop_lead", 2'd0, 1'b0, 1'b1, 8'd4);
    bus.en = 1'b1; step();
    bus.err_in = 1'b1; step(); step(); bus.err_in = 1'b0;
    expect_out("relead", 2'd2, 1'b1, 1'b0, 8'd5);

    // sw_cnt saturation: alternate ORIGIN/LEAD well past 255 switches.
    bus.en = 1'b0; step();
    bus.cfg_thresh = 4'd1; bus.cfg_hold = 8'd0;
    bus.en = 1'b1; step();
    for (int i = 0; i < 260; i++) begin
      bus.err_in = 1'b1; step();
      bus.err_in = 1'b0; step();
    end
    expect_out("sw_saturated", 2'd1, 1'b1, 1'b1, 8'd255);
    bus.err_in = 1'b1; step(); bus.err_in = 1'b0;
    expect_out("sw_sat_lead", 2'd2, 1'b1, 1'b0, 8'd255);

    // Asynchronous reset mid-LEAD: outputs return without a clock edge.
    rst = 1'b1;
    #1;
    expect_out("async_rst_lead", 2'd0, 1'b0, 1'b1, 8'd0);
    step();
    expect_out("rst_held_en1", 2'd0, 1'b0, 1'b1, 8'd0);
    #4 rst = 1'b0;
    step();
    expect_out("rst_release_en1", 2'd1, 1'b1, 1'b1, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
